// File: rtl/systolic_feed_ctrl_pkg.sv
// Shared constants, FSM state type and lane helper for the systolic feed sequencer.
package systolic_pkg;

  localparam int unsigned N          = 4;
  localparam int unsigned FEED_STEPS = 2 * N - 1;
  localparam int unsigned STEP_W     = $clog2(FEED_STEPS);
  localparam int unsigned IDX_W      = $clog2(N);
  localparam int unsigned MASK_W     = 2 * N;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Bit offset of lane `lane` in a vector of `dw`-wide packed lanes.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/systolic_feed_ctrl_if.sv
// Operand load port: host (master) writes A rows / B columns into the sequencer (slave).
interface systolic_feed_ctrl_if
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                      ld_valid_i;
  logic                      ld_ready_o;
  logic                      ld_sel_i;
  logic [IDX_W-1:0]          ld_idx_i;
  logic [N*DATA_WIDTH-1:0]   ld_data_i;

  modport master (
    output ld_valid_i, ld_sel_i, ld_idx_i, ld_data_i,
    input  ld_ready_o
  );

  modport slave (
    input  ld_valid_i, ld_sel_i, ld_idx_i, ld_data_i,
    output ld_ready_o
  );

endinterface

// File: rtl/systolic_feed_ctrl_skew_buf.sv
// A-row / B-column operand store with loaded mask and skewed, zero-padded wavefront select.
module systolic_skew_buf
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    wr_en_i,
  input  logic                    wr_sel_i,
  input  logic [IDX_W-1:0]        wr_idx_i,
  input  logic [N*DATA_WIDTH-1:0] wr_data_i,
  input  logic [STEP_W-1:0]       step_i,
  output logic [MASK_W-1:0]       mask_o,
  output logic [N*DATA_WIDTH-1:0] left_o,
  output logic [N*DATA_WIDTH-1:0] up_o
);

  // a_q[i] holds A row i; b_q[j] holds B column j (element k = B[k][j]).
  logic [N*DATA_WIDTH-1:0] a_q [N];
  logic [N*DATA_WIDTH-1:0] a_d [N];
  logic [N*DATA_WIDTH-1:0] b_q [N];
  logic [N*DATA_WIDTH-1:0] b_d [N];
  logic [MASK_W-1:0]       mask_q, mask_d;

  // Slot write and mask update on a load handshake.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    mask_d = mask_q;
    if (wr_en_i) begin
      if (wr_sel_i) begin
        b_d[wr_idx_i]          = wr_data_i;
        mask_d[N + wr_idx_i]   = 1'b1;
      end else begin
        a_d[wr_idx_i]          = wr_data_i;
        mask_d[wr_idx_i]       = 1'b1;
      end
    end
  end

  // Mask is reset; operand storage is not, since the mask gates its use.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  // Operand storage registers.
  always_ff @(posedge clk_i) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign mask_o = mask_q;

  // Wavefront: lane i of left carries A[i][s-i], lane j of up carries B[s-j][j], else 0.
  always_comb begin
    left_o = '0;
    up_o   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (32'(step_i) >= i && (32'(step_i) - i) < N) begin
        left_o[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] =
          a_q[i][lane_lsb(32'(step_i) - i, DATA_WIDTH) +: DATA_WIDTH];
        up_o[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] =
          b_q[i][lane_lsb(32'(step_i) - i, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Sequencer for the 4x4 output-stationary systolic multiplier: clear, skewed feed, drain, report.
module systolic_feed_ctrl
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  systolic_feed_ctrl_if.slave     ld,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic                    start_err_o,
  output logic [N*DATA_WIDTH-1:0] left_o,
  output logic [N*DATA_WIDTH-1:0] up_o,
  output logic                    array_rst_no,
  input  logic                    array_done_i
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  state_e                  state_q, state_d;
  logic [STEP_W-1:0]       step_q, step_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic                    ld_ready_q, ld_ready_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    start_err_q, start_err_d;
  logic                    arst_n_q, arst_n_d;
  logic [N*DATA_WIDTH-1:0] left_q, left_d;
  logic [N*DATA_WIDTH-1:0] up_q, up_d;

  logic                    ld_fire;
  logic [MASK_W-1:0]       mask;
  logic [N*DATA_WIDTH-1:0] skew_left, skew_up;
  logic                    timeout;

  assign ld_fire = ld.ld_valid_i & ld_ready_q;

  // The skew select is driven by the next step so the wavefront lands in the output flops in step.
  systolic_skew_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skew_buf (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (ld_fire),
    .wr_sel_i  (ld.ld_sel_i),
    .wr_idx_i  (ld.ld_idx_i),
    .wr_data_i (ld.ld_data_i),
    .step_i    (step_d),
    .mask_o    (mask),
    .left_o    (skew_left),
    .up_o      (skew_up)
  );

  // Next-state, counters and next-output values; outputs are decoded from the next state.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    wait_d      = wait_q;
    timeout     = 1'b0;
    start_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (&mask) state_d = ST_CLEAR;
          else       start_err_d = 1'b1;
        end
      end
      ST_CLEAR: begin
        state_d = ST_FEED;
        step_d  = '0;
      end
      ST_FEED: begin
        if (step_q == STEP_W'(FEED_STEPS - 1)) begin
          state_d = ST_DRAIN;
          wait_d  = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (array_done_i) begin
          state_d = ST_DONE;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          state_d = ST_DONE;
          timeout = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    ld_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    err_d      = timeout;
    arst_n_d   = (state_d != ST_CLEAR);
    left_d     = (state_d == ST_FEED) ? skew_left : '0;
    up_d       = (state_d == ST_FEED) ? skew_up   : '0;
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      wait_q      <= '0;
      ld_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      start_err_q <= 1'b0;
      arst_n_q    <= 1'b0;
      left_q      <= '0;
      up_q        <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      wait_q      <= wait_d;
      ld_ready_q  <= ld_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      start_err_q <= start_err_d;
      arst_n_q    <= arst_n_d;
      left_q      <= left_d;
      up_q        <= up_d;
    end
  end

  assign ld.ld_ready_o  = ld_ready_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign start_err_o    = start_err_q;
  assign array_rst_no   = arst_n_q;
  assign left_o         = left_q;
  assign up_o           = up_q;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Scoreboard bench for systolic_feed_ctrl with a behavioural 4x4 output-stationary array.
module tb_systolic_feed_ctrl;

  localparam int DW = 32;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         busy, done, err, start_err, arst_n, adone;
  logic [127:0] left, up;

  always #5 clk = ~clk;

  systolic_feed_ctrl_if #(.DATA_WIDTH(DW)) ld_if ();

  systolic_feed_ctrl #(
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ld           (ld_if.slave),
    .start_i      (start),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .start_err_o  (start_err),
    .left_o       (left),
    .up_o         (up),
    .array_rst_no (arst_n),
    .array_done_i (adone)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural array: left values shift right, up values shift down, each PE accumulates.
  logic [31:0] lr  [4][4];
  logic [31:0] ur  [4][4];
  logic [31:0] acc [4][4];
  int          dcnt;
  bit          tie_low = 1'b0;

  always @(posedge clk) begin
    if (!arst_n) begin
      dcnt <= 0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          lr[i][j]  <= '0;
          ur[i][j]  <= '0;
          acc[i][j] <= '0;
        end
    end else begin
      dcnt <= dcnt + 1;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          lr[i][j]  <= (j == 0) ? left[i*32 +: 32] : lr[i][j-1];
          ur[i][j]  <= (i == 0) ? up[j*32 +: 32]   : ur[i-1][j];
          acc[i][j] <= acc[i][j] + lr[i][j] * ur[i][j];
        end
    end
  end
  assign adone = (dcnt >= 14) && !tie_low;

  typedef struct {
    int           step;
    logic [127:0] l;
    logic [127:0] u;
  } wave_t;

  typedef struct {
    logic        err;
    int          t0;
    int          lat;
    bit          chk;
    logic [31:0] c00, c03, c30, c33;
  } run_t;

  wave_t wave_q[$];
  run_t  run_q[$];
  int    se_q[$];
  int    done_seen = 0;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [127:0] pk(input int l3, input int l2, input int l1, input int l0);
    return {32'(l3), 32'(l2), 32'(l1), 32'(l0)};
  endfunction

  // Monitor: pops expectations whenever the DUT presents a wavefront step, done or start error.
  int    feed_idx = -2;
  wave_t mw;
  run_t  mr;
  int    mt0;
  always @(negedge clk) begin
    if (!busy)        feed_idx = -2;
    else if (!arst_n) feed_idx = -1;
    else if (feed_idx >= -1) feed_idx++;

    if (feed_idx >= 0 && wave_q.size() > 0 && wave_q[0].step == feed_idx) begin
      mw = wave_q.pop_front();
      check($sformatf("left_s%0d", mw.step), left, mw.l);
      check($sformatf("up_s%0d", mw.step), up, mw.u);
    end

    if (done) begin
      done_seen++;
      if (run_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done_o=1 expected no run pending");
      end else begin
        mr = run_q.pop_front();
        check("done_err", 128'(err), 128'(mr.err));
        check("done_latency", 128'(cyc - mr.t0), 128'(mr.lat));
        check("busy_at_done", 128'(busy), 128'(1));
        if (mr.chk) begin
          check("res_0",  128'(acc[0][0]), 128'(mr.c00));
          check("res_3",  128'(acc[0][3]), 128'(mr.c03));
          check("res_12", 128'(acc[3][0]), 128'(mr.c30));
          check("res_15", 128'(acc[3][3]), 128'(mr.c33));
        end
      end
    end

    if (start_err) begin
      if (se_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_start_err: got start_err_o=1 expected 0");
      end else begin
        mt0 = se_q.pop_front();
        check("start_err_latency", 128'(cyc - mt0), 128'(1));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [127:0] a_row(input int i, input int m);
    if (i == 0) return pk(4*m, 3*m, 2*m, m);
    return pk(4*i+4, 4*i+3, 4*i+2, 4*i+1);
  endfunction

  function automatic logic [127:0] b_col(input int j);
    return pk(j+1, j+1, j+1, j+1);
  endfunction

  task automatic do_load(input bit sel, input int idx, input logic [127:0] d);
    int n = 0;
    while (!ld_if.ld_ready_o && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL load_wait: got ld_ready_o=0 expected 1 within 50 cycles");
    end
    ld_if.ld_valid_i = 1'b1;
    ld_if.ld_sel_i   = sel;
    ld_if.ld_idx_i   = 2'(idx);
    ld_if.ld_data_i  = d;
    tick();
    ld_if.ld_valid_i = 1'b0;
  endtask

  // Hand-computed wavefront for A = 1..16 (row 0 scaled by m), B[k][j] = j+1.
  task automatic push_waves(input int m, input bit full);
    wave_q.push_back('{0, pk(0, 0, 0, m),         pk(0, 0, 0, 1)});
    wave_q.push_back('{3, pk(13, 10, 7, 4*m),     pk(4, 3, 2, 1)});
    if (full) begin
      wave_q.push_back('{6, pk(16, 0, 0, 0),      pk(4, 0, 0, 0)});
      wave_q.push_back('{7, '0,                   '0});
    end
  endtask

  task automatic push_run(input bit to, input int m);
    run_t r;
    r.err = to;
    r.t0  = cyc;
    r.lat = to ? 9 + TO : 17;
    r.chk = !to;
    r.c00 = 32'(10 * m);
    r.c03 = 32'(40 * m);
    r.c30 = 32'd58;
    r.c33 = 32'd232;
    run_q.push_back(r);
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_seen == d0 && n < 60) begin tick(); n++; end
    if (n >= 60) begin
      checks++; errors++;
      $display("FAIL done_wait: got no done_o expected one within 60 cycles");
    end
    tick(); tick();
    check("ld_ready_after_run", 128'(ld_if.ld_ready_o), 128'(1));
    check("busy_after_run", 128'(busy), 128'(0));
  endtask

  task automatic run(input bit to, input bit poke);
    int d0 = done_seen;
    tie_low = to;
    push_waves(1, 1'b1);
    push_run(to, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (poke) begin
      tick(); tick();
      check("ld_ready_busy", 128'(ld_if.ld_ready_o), 128'(0));
      ld_if.ld_valid_i = 1'b1;
      ld_if.ld_sel_i   = 1'b1;
      ld_if.ld_idx_i   = 2'd0;
      ld_if.ld_data_i  = '1;
      start = 1'b1;
      tick();
      ld_if.ld_valid_i = 1'b0;
      start = 1'b0;
    end
    wait_done(d0);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0;
    start = 1'b0;
    ld_if.ld_valid_i = 1'b0;
    ld_if.ld_sel_i   = 1'b0;
    ld_if.ld_idx_i   = '0;
    ld_if.ld_data_i  = '0;
    repeat (3) tick();
    check("reset_outs", {ld_if.ld_ready_o, busy, done, err, start_err, arst_n, left, up}, '0);
    rst_n = 1'b1;
    tick();
    check("ld_ready_post_reset", 128'(ld_if.ld_ready_o), 128'(1));
    check("array_rst_post_reset", 128'(arst_n), 128'(1));

    // Seven of eight slots, then a rejected start.
    for (int i = 0; i < 4; i++) do_load(1'b0, i, a_row(i, 1));
    for (int j = 0; j < 3; j++) do_load(1'b1, j, b_col(j));
    se_q.push_back(cyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("busy_incomplete", 128'(busy), 128'(0));
    check("outs_incomplete", {left, up}, '0);

    // Last slot loaded in the same cycle as start: the start still sees the old mask.
    se_q.push_back(cyc);
    ld_if.ld_valid_i = 1'b1;
    ld_if.ld_sel_i   = 1'b1;
    ld_if.ld_idx_i   = 2'd3;
    ld_if.ld_data_i  = b_col(3);
    start = 1'b1;
    tick();
    ld_if.ld_valid_i = 1'b0;
    start = 1'b0;
    tick();
    check("busy_same_cycle_reject", 128'(busy), 128'(0));

    run(1'b0, 1'b1);   // normal run with load/start pokes while busy
    run(1'b0, 1'b0);   // rerun without reload
    run(1'b1, 1'b0);   // timeout

    // Row 0 reloaded doubled in the same cycle as start: the run uses the new data.
    d0 = done_seen;
    tie_low = 1'b0;
    push_waves(2, 1'b1);
    push_run(1'b0, 2);
    ld_if.ld_valid_i = 1'b1;
    ld_if.ld_sel_i   = 1'b0;
    ld_if.ld_idx_i   = 2'd0;
    ld_if.ld_data_i  = a_row(0, 2);
    start = 1'b1;
    tick();
    ld_if.ld_valid_i = 1'b0;
    start = 1'b0;
    wait_done(d0);

    // Reset during FEED s=3.
    push_waves(2, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    check("reset_mid_outs", {ld_if.ld_ready_o, busy, done, err, start_err, arst_n, left, up}, '0);
    rst_n = 1'b1;
    tick();
    check("ld_ready_after_mid_reset", 128'(ld_if.ld_ready_o), 128'(1));
    se_q.push_back(cyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("busy_after_mask_clear", 128'(busy), 128'(0));

    repeat (5) tick();
    check("wave_q_empty", 128'(wave_q.size()), 128'(0));
    check("run_q_empty", 128'(run_q.size()), 128'(0));
    check("se_q_empty", 128'(se_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_feed_ctrl.md
# systolic_feed_ctrl

Sequencer for the 4x4 output-stationary systolic multiplier (SYSTOLIC_MUL). It buffers matrix A by row and matrix B by column through a load port. On start it clears the array, then drives the skewed, zero-padded operand wavefront on the array's four left and four top inputs. It then waits for the array's completion flag and reports done or timeout to the host.

## Interface
Parameters:
- DATA_WIDTH, 32, operand width; must match the array.
- TIMEOUT, 16, maximum DRAIN cycles to wait for array_done_i.

Ports:
- clk_i  in  1  single clock; all logic rising-edge.
- rst_ni  in  1  reset, synchronous, active-low.
- ld_valid_i  in  1  load strobe.
- ld_ready_o  out  1  high only in IDLE.
- ld_sel_i  in  1  0 = A row, 1 = B column.
- ld_idx_i  in  2  row index (A) or column index (B).
- ld_data_i  in  4*DATA_WIDTH  element k at bits [k*DW +: DW]; A[idx][k] or B[k][idx].
- start_i  in  1  run request.
- busy_o  out  1  high from CLEAR through DONE.
- done_o  out  1  one-cycle pulse at run end.
- err_o  out  1  valid with done_o; 1 = timeout.
- start_err_o  out  1  one-cycle pulse when start_i is rejected.
- left_o  out  4*DATA_WIDTH  to array left_i_0/4/8/12; lane i = row i.
- up_o  out  4*DATA_WIDTH  to array up_i_0..3; lane j = column j.
- array_rst_no  out  1  to array rst_ni.
- array_done_i  in  1  from array done.

## Operation
- Buffers: 4 A rows and 4 B columns, plus an 8-bit loaded mask. A handshake (ld_valid_i & ld_ready_o) writes one slot and sets its mask bit. Reloading a slot overwrites it.
- Buffers and mask persist after a run, so start_i can rerun the same operands.
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE -> CLEAR when start_i is high and the mask was all-ones at the start of the cycle.
- start_i in IDLE with an incomplete mask: start_err_o pulses and the FSM stays in IDLE.
- start_i in any state other than IDLE is ignored with no error.
- CLEAR: 1 cycle, array_rst_no=0. Then go to FEED.
- FEED: step counter s = 0..6, 7 cycles.
  - Lane i of left_o = A[i][s-i] when 0 ≤ s-i ≤ 3, else 0.
  - Lane j of up_o = B[s-j][j] when 0 ≤ s-j ≤ 3, else 0.
  - After s=6, go to DRAIN.
- DRAIN: left_o and up_o are 0 and a wait counter runs.
  - array_done_i sampled high -> DONE with err_o=0.
  - TIMEOUT cycles elapse without it -> DONE with err_o=1.
- DONE: 1 cycle; done_o=1 and err_o is valid. Then go to IDLE.
- In all states other than FEED, left_o and up_o are 0. In all states other than CLEAR and reset, array_rst_no=1.
- Load and start in the same IDLE cycle: the load is committed and its data is used by the run. The start check uses the mask from before that cycle.
- No arithmetic: the block only selects and zero-pads operands. Widths pass through unchanged.

## Timing
- All outputs are registered.
- Reset values: ld_ready_o=0, busy_o=0, done_o=0, err_o=0, start_err_o=0, left_o=0, up_o=0, array_rst_no=0, mask=0.
- First cycle after reset: IDLE, ld_ready_o=1, array_rst_no=1.
- Reset asserted mid-run (any state): the next edge returns the FSM to IDLE and clears the mask. All outputs take their reset values. No done_o pulse.
- start_i sampled at edge 0:
  - CLEAR is visible in cycle 1.
  - FEED steps s=0..6 are visible in cycles 2..8.
  - DRAIN begins in cycle 9.
- done_o appears in the cycle after array_done_i is sampled high. On timeout it appears in cycle 9+TIMEOUT.
- busy_o is high in cycles 1 through the done_o cycle, inclusive.
- ld_ready_o falls in cycle 1 and returns in the cycle after done_o.

## Structure
- Shared package systolic_pkg:
  - N=4.
  - FEED_STEPS = 2N-1.
  - FSM state enum.
  - Lane slice helper for DATA_WIDTH-packed vectors.
- One sub-module, systolic_skew_buf, holds the A/B buffers and the mask, and performs the combinational skew select from the step counter.
- The FSM, counters and output registers live in the top module.

## Test plan
- Correctness: load A = 1..16 row-major and B[k][j] = j+1, then start with the real array attached.
  - FEED s=0 drives left_o lane 0 = 1 and up_o lane 0 = 1; all other lanes are 0.
  - At done_o: res_o_0 = 10, res_o_3 = 40, res_o_12 = 58, res_o_15 = 232, err_o = 0.
- Incomplete load: load 7 of 8 slots, then pulse start_i -> start_err_o pulses once, busy_o stays 0, outputs stay 0.
- Timeout: tie array_done_i = 0 and start -> done_o with err_o = 1 in cycle 25 after start (TIMEOUT = 16).
- Reset mid-run: drive rst_ni low for one cycle during FEED s=3.
  - Next cycle: all outputs take their reset values, then the FSM is in IDLE with mask 0.
  - A following start_i -> start_err_o.
- Busy behaviour: during a run, ld_valid_i gets no handshake and the buffer is unchanged, and start_i has no effect.
- Rerun: start again after done_o with no reload -> identical results.
